// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the 5-stage MIPS pipeline.
// Holds the PC and fetches from instruction memory over a req/ready handshake.
// The fetched word and its PC are registered into the IF/ID boundary.
// The stage also handles ID stalls, branch/jump redirects and a halt sentinel.
//
// Ports:
//   clk, rst_n          pipeline clock (rising edge), async active-low reset
//   imem_req/addr       fetch request and byte address (req held until ready)
//   imem_ready/rdata    response strobe and instruction word
//   stall               ID hazard stall: IF/ID outputs hold
//   redirect/_pc        taken branch/jump: flush and refetch from redirect_pc
//   instruction, pc_out IF/ID instruction word and its PC
//   pc_plus4            pc_out + 4 (wraps)
//   valid               instruction is real (0 = bubble)
//   halted              HALT_INSTR delivered, fetch stopped until reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        req_state;

  assign req_state = (state_q == S_FETCH) || (state_q == S_DROP);
  // The request is masked combinationally so nothing is issued during reset.
  assign imem_req  = rst_n && req_state;
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;
  assign valid       = valid_q;
  assign halted      = halted_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    drop_addr_d = drop_addr_q;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          // An in-flight request must still be completed; remember its address.
          if (!imem_ready) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (stall) begin
          if (imem_ready) begin
            buf_d    = imem_rdata;
            buf_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_HOLD;
          end
        end else if (imem_ready) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
          if (imem_rdata == HALT_INSTR) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d  = buf_q;
          pc_out_d = buf_pc_q;
          valid_d  = 1'b1;
          if (buf_q == HALT_INSTR) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_DROP: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        if (imem_ready) begin
          state_d = S_FETCH;
        end
      end

      default: begin // S_HALT
        if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      buf_q       <= '0;
      buf_pc_q    <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of Instruction_decode. Holds the PC and issues requests to instruction memory over a req/ready handshake. Registers the fetched word and its PC into the IF/ID boundary. Handles stall (hold), redirect from branch/jump (flush and bubble), and a halt sentinel.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble word driven on flush/no-data
HALT_INSTR, 32'hFFFF_FFFF, sentinel word that stops fetching

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; held high until imem_ready
imem_addr  output  32  byte address of requested word
imem_ready  input  1  imem_rdata valid this cycle; transfer occurs on edge with imem_req && imem_ready
imem_rdata  input  32  instruction word
stall  input  1  ID hazard stall; IF/ID outputs must hold
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  target PC, valid with redirect
instruction  output  32  IF/ID instruction, feeds Instruction_decode.instruction
pc_out  output  32  PC of instruction
pc_plus4  output  32  pc_out + 4, modulo 2^32
valid  output  1  instruction is real (0 = bubble)
halted  output  1  HALT_INSTR delivered; fetch stopped

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, instruction=NOP_INSTR, pc_out=0, valid=0, halted=0, buffer cleared. imem_req forced 0 while rst_n=0. Reset mid-request abandons the request; no response is consumed.
- States: FETCH, HOLD, DROP, HALT.
- imem_req=1 in FETCH and DROP only. imem_addr=pc in FETCH, drop_addr in DROP, pc otherwise.
- Priority, highest first: reset, redirect, stall, normal.
- FETCH, transfer, stall=0, no redirect:
  - instruction<=rdata, pc_out<=pc, valid<=1, pc<=pc+4.
  - If rdata==HALT_INSTR, go to HALT and set halted<=1 on the same edge.
  - Latency: word appears on outputs the edge after imem_ready is sampled.
- FETCH, no transfer, stall=0: instruction<=NOP_INSTR, valid<=0 (bubble). pc unchanged.
- FETCH, transfer, stall=1: buf<=rdata, buf_pc<=pc, pc<=pc+4, go to HOLD. Outputs unchanged.
- FETCH, no transfer, stall=1: everything holds. imem_req stays high.
- HOLD (imem_req=0):
  - While stall=1: hold.
  - At stall=0: outputs<=buf/buf_pc, valid<=1, then go to FETCH, or to HALT if buf==HALT_INSTR.
- Redirect (any state except HALT), regardless of stall:
  - instruction<=NOP_INSTR, valid<=0, pc<=redirect_pc.
  - FETCH with transfer this cycle: word discarded, stay in FETCH.
  - FETCH without transfer: drop_addr<=current imem_addr, go to DROP.
  - HOLD: buf discarded, go to FETCH.
  - DROP: pc updated, stay in DROP.
- DROP: imem_req held on drop_addr until imem_ready. Response discarded (outputs bubble unless stall=1, then hold). Go to FETCH on transfer.
- HALT:
  - imem_req=0, halted=1 until reset.
  - When stall=0, outputs become NOP_INSTR with valid=0 on each edge after the halt word has been taken.
  - Redirect is ignored in HALT.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0. pc_plus4 wraps the same way.
- No misalignment checking; redirect_pc[1:0] is passed through unmodified.

Test Plan:
- Reset, then imem_ready=1 every cycle with rdata=addr+0x100 → pc_out sequence 0,4,8,… with instruction 0x100,0x104,… and valid=1 each cycle after first transfer. imem_addr=0 during first cycle after rst_n rises.
- imem_ready low 3 cycles at addr 8 → 3 bubbles (valid=0, instruction=0). Then pc_out=8; imem_req high throughout the wait.
- stall=1 for 4 cycles while transfer of addr 0xC occurs → outputs hold previous word (pc_out=8), imem_req=0 after transfer. On release, pc_out=0xC, then next fetch addr 0x10.
- redirect with redirect_pc=0x40 while imem_ready=0 at addr 0x10 → next edge valid=0. imem_addr stays 0x10 until ready, that word discarded, next fetch addr 0x40, pc_out=0x40.
- Simultaneous redirect and stall=1 in HOLD → buffered word never emitted. valid=0, fetch resumes at redirect_pc.
- rdata=0xFFFF_FFFF at addr 0x20 → pc_out=0x20 valid=1 once, halted=1, imem_req=0 thereafter. Later redirect ignored. rst_n pulse low restores pc=0, halted=0.
